// File: rtl/serial_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and default word width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Bundle of the parallel-input handshake and the serial output lines of the serializer.
interface piso_serializer_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sdata;
    logic             sload;
    logic             word_done;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sdata,
        input  sload,
        input  word_done,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sdata,
        output sload,
        output word_done,
        output busy
    );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: accepts a word on a valid/ready handshake and shifts it out
// MSB first, driving the load line of a downstream shift register; back-to-back words have no gap.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_serializer_if.slave bus
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             ready_int;
    logic             xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // A new word loading on the last-bit edge overrides the return to IDLE, giving back-to-back words.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        last_bit  = (state_q == SHIFT) && (cnt_q == LAST);
        ready_int = (state_q == IDLE) || last_bit;
        xfer      = bus.din_valid && ready_int;

        if (state_q == SHIFT) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end

        if (xfer) begin
            shreg_d = bus.din;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

    // Ready is gated by rst_n so upstream never sees a handshake while reset is held.
    assign bus.din_ready = rst_n && ready_int;
    assign bus.sdata     = (state_q == SHIFT) && shreg_q[WIDTH-1];
    assign bus.sload     = (state_q == SHIFT);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.word_done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a WIDTH=4 instance feeding a 4-bit SIPO sink, plus a WIDTH=8 instance.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [3:0] sinkQ;
    int         nVectors;
    int         nMiscompares;

    piso_serializer_if #(.WIDTH(4)) busA ();
    piso_serializer_if #(.WIDTH(8)) busB ();

    piso_serializer #(.WIDTH(4)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    piso_serializer #(.WIDTH(8)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream consumer: shifts {q[2:0], d} whenever load is high.
    initial sinkQ = 4'h0;
    always @(posedge clk) begin
        if (busA.sload) sinkQ <= {sinkQ[2:0], busA.sdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] word, input logic valid);
        busA.din       = word;
        busA.din_valid = valid;
    endtask

    // Offer one word for one cycle on the WIDTH=4 instance and check its bits, pulse and sink.
    task automatic sendWordA(input logic [3:0] w, input string tag);
        applyStimulus(w, 1'b1);
        tick();
        applyStimulus(4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, " sdata"}, 32'(busA.sdata), 32'(w[3-i]));
            checkOutput({tag, " sload"}, 32'(busA.sload), 32'd1);
            checkOutput({tag, " busy"}, 32'(busA.busy), 32'd1);
            checkOutput({tag, " done low"}, 32'(busA.word_done), 32'd0);
            checkOutput({tag, " ready"}, 32'(busA.din_ready), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput({tag, " done pulse"}, 32'(busA.word_done), 32'd1);
        checkOutput({tag, " sink q"}, 32'(sinkQ), 32'(w));
        checkOutput({tag, " idle sload"}, 32'(busA.sload), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(busA.busy), 32'd0);
        tick();
        checkOutput({tag, " done cleared"}, 32'(busA.word_done), 32'd0);
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, " sdata"}, 32'(busA.sdata), 32'd0);
        checkOutput({tag, " sload"}, 32'(busA.sload), 32'd0);
        checkOutput({tag, " busy"}, 32'(busA.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(busA.word_done), 32'd0);
        checkOutput({tag, " ready"}, 32'(busA.din_ready), 32'd0);
    endtask

    initial begin
        logic [3:0] words [3];
        logic [7:0] wideWord;
        logic [3:0] bpWord;

        nVectors     = 0;
        nMiscompares = 0;
        rst_n        = 1'b0;
        applyStimulus(4'h0, 1'b0);
        busB.din       = 8'h00;
        busB.din_valid = 1'b0;

        #3;
        checkAllLow("reset");
        checkOutput("reset ready B", 32'(busB.din_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset ready", 32'(busA.din_ready), 32'd1);

        sendWordA(4'b1011, "single");

        words[0] = 4'hA;
        words[1] = 4'h5;
        words[2] = 4'hF;
        applyStimulus(words[0], 1'b1);
        tick();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("b2b sload", 32'(busA.sload), 32'd1);
                checkOutput("b2b sdata", 32'(busA.sdata), 32'(words[w][3-i]));
                checkOutput("b2b ready", 32'(busA.din_ready), (i == 3) ? 32'd1 : 32'd0);
                if (i == 0 && w > 0) begin
                    checkOutput("b2b done", 32'(busA.word_done), 32'd1);
                    checkOutput("b2b sink q", 32'(sinkQ), 32'(words[w-1]));
                end else begin
                    checkOutput("b2b done low", 32'(busA.word_done), 32'd0);
                end
                if (i == 3) begin
                    if (w < 2) applyStimulus(words[w+1], 1'b1);
                    else       applyStimulus(4'h0, 1'b0);
                end
                tick();
            end
        end
        checkOutput("b2b last done", 32'(busA.word_done), 32'd1);
        checkOutput("b2b last sink q", 32'(sinkQ), 32'hF);
        checkOutput("b2b idle", 32'(busA.sload), 32'd0);
        tick();

        // A held word 3 must wait behind word 9 until the last-bit edge.
        bpWord = 4'h9;
        applyStimulus(bpWord, 1'b1);
        tick();
        applyStimulus(4'h3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp ready", 32'(busA.din_ready), (i == 3) ? 32'd1 : 32'd0);
            checkOutput("bp sdata", 32'(busA.sdata), 32'(bpWord[3-i]));
            tick();
        end
        applyStimulus(4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp second sload", 32'(busA.sload), 32'd1);
            checkOutput("bp second sdata", 32'(busA.sdata), (i >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput("bp done", 32'(busA.word_done), 32'd1);
        checkOutput("bp sink q", 32'(sinkQ), 32'h3);
        tick();
        checkOutput("bp no duplicate", 32'(busA.busy), 32'd0);

        applyStimulus(4'hC, 1'b1);
        tick();
        applyStimulus(4'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkAllLow("midreset");
        tick();
        checkAllLow("midreset held");
        rst_n = 1'b1;
        #1;
        checkOutput("midreset ready", 32'(busA.din_ready), 32'd1);
        tick();
        checkOutput("midreset no done", 32'(busA.word_done), 32'd0);
        sendWordA(4'h6, "after reset");

        sendWordA(4'h1, "gap first");
        for (int i = 0; i < 5; i++) begin
            checkOutput("gap sload", 32'(busA.sload), 32'd0);
            checkOutput("gap sdata", 32'(busA.sdata), 32'd0);
            tick();
        end
        sendWordA(4'h8, "gap second");

        wideWord       = 8'hA5;
        busB.din       = wideWord;
        busB.din_valid = 1'b1;
        tick();
        busB.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("w8 sdata", 32'(busB.sdata), 32'(wideWord[7-i]));
            checkOutput("w8 busy", 32'(busB.busy), 32'd1);
            checkOutput("w8 done low", 32'(busB.word_done), 32'd0);
            tick();
        end
        checkOutput("w8 done", 32'(busB.word_done), 32'd1);
        checkOutput("w8 sload idle", 32'(busB.sload), 32'd0);
        tick();
        checkOutput("w8 done cleared", 32'(busB.word_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
